flash_sdram_bridge: RTL and testbench

Buffers byte-write requests issued by the cartridge flash emulator and arbitrates them with cartridge read requests onto a single SDRAM controller port. Sits between the flash command decoder, which drives `sdram_req`/`sdram_addr`/`sdram_din`, and the shared SDRAM client port. It returns the `sdram_ready`/`sdram_done` handshake the flash emulator expects. Reads keep priority so Z80 slot accesses are not starved during erase fills.

---
 rtl/flash_bridge_pkg.sv | 31 +++
 rtl/flash_wr_fifo.sv | 87 ++++++++
 rtl/flash_sdram_bridge.sv | 154 +++++++++++++++
 tb/tb_flash_sdram_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_bridge_pkg.sv
// flash_bridge_pkg: shared state encoding, write-entry type and defaults for
// the flash-emulator-to-SDRAM write bridge.
package flash_bridge_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_AW    = 25;

  // Entries are stored with the widest supported address; the bridge only
  // ever fills and compares the low AW bits, the rest stay zero.
  localparam int MAX_AW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic [7:0]        data;
  } wr_entry_t;

  function automatic wr_entry_t make_entry(input logic [MAX_AW-1:0] addr,
                                           input logic [7:0]        data);
    wr_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/flash_wr_fifo.sv
// flash_wr_fifo: circular write buffer between the flash emulator and the
// SDRAM arbiter. Head/tail pointers wrap at DEPTH (a power of two) and an
// occupancy counter gives full/empty. With FLASH_WR_FORWARD_EN defined it also
// exposes a lookup port returning the youngest queued byte for an address.
module flash_wr_fifo
  import flash_bridge_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [AW-1:0]          head_addr,
  output logic [7:0]             head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
`ifdef FLASH_WR_FORWARD_EN
  ,
  input  logic [AW-1:0]          match_addr,
  output logic                   match_hit,
  output logic [7:0]             match_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_entry_t      entries [DEPTH];
  wr_entry_t      head_entry;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;

  // Storage is written at the tail on every push; contents need no reset
  // because validity is derived from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= make_entry(MAX_AW'(push_addr), push_data);
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_entry = entries[head];
  assign head_addr  = AW'(head_entry.addr);
  assign head_data  = head_entry.data;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

`ifdef FLASH_WR_FORWARD_EN
  logic [PW-1:0] scan_idx;

  // Walk valid entries oldest to youngest so the last hit is the newest data.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PW'(k);
      if ((CW'(k) < count) && (entries[scan_idx].addr == MAX_AW'(match_addr))) begin
        match_hit  = 1'b1;
        match_data = entries[scan_idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/flash_sdram_bridge.sv
// flash_sdram_bridge: queues flash-emulator byte writes and shares one SDRAM
// client port between them and cartridge reads. Reads win arbitration unless
// the write queue is full. Build option FLASH_WR_FORWARD_EN lets reads hit
// queued writes; without it a read waits until the queue has drained.
module flash_sdram_bridge
  import flash_bridge_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_req,
  input  logic [AW-1:0]          wr_addr,
  input  logic [7:0]             wr_din,
  output logic                   wr_ready,
  output logic                   wr_done,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic [7:0]             rd_dout,
  output logic                   rd_done,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [7:0]             mem_din,
  input  logic [7:0]             mem_dout,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] wr_pending
);

  state_t        state;
  logic          fifo_full;
  logic          fifo_empty;
  logic          wr_accept;
  logic          fifo_pop;
  logic          rd_pending;
  logic          rd_eligible;
  logic [AW-1:0] head_addr;
  logic [7:0]    head_data;

  // The wr_done term stops a second accept while the emulator drops wr_req;
  // rd_done does the same for the read side.
  assign wr_accept  = wr_req & ~fifo_full & ~wr_done;
  assign rd_pending = rd_req & ~rd_done;
  assign fifo_pop   = (state == ST_WR) & mem_req & mem_ack;
  assign wr_ready   = ~fifo_full;

`ifdef FLASH_WR_FORWARD_EN
  logic       fwd_hit;
  logic [7:0] fwd_data;

  flash_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (wr_accept),
    .push_addr  (wr_addr),
    .push_data  (wr_din),
    .pop        (fifo_pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (wr_pending),
    .match_addr (rd_addr),
    .match_hit  (fwd_hit),
    .match_data (fwd_data)
  );

  // A full queue forces a write first so a read cannot starve the drain.
  assign rd_eligible = rd_pending & ~fwd_hit & ~fifo_full;
`else
  flash_wr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_accept),
    .push_addr (wr_addr),
    .push_data (wr_din),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (wr_pending)
  );

  // Without forwarding a read may only see SDRAM once every write has landed.
  assign rd_eligible = rd_pending & fifo_empty;
`endif

  // Arbiter FSM with registered SDRAM request and handshake pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rd_done  <= 1'b0;
      rd_dout  <= '0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= wr_accept;
      rd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef FLASH_WR_FORWARD_EN
          if (rd_pending && fwd_hit) begin
            rd_done <= 1'b1;
            rd_dout <= fwd_data;
          end
`endif
          if (rd_eligible) begin
            state    <= ST_RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr;
            mem_din  <= '0;
          end else if (!fifo_empty) begin
            state    <= ST_WR;
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= head_addr;
            mem_din  <= head_data;
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            rd_done  <= 1'b1;
            rd_dout  <= mem_dout;
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sdram_bridge.sv
// tb_flash_sdram_bridge: directed vector table for the write path plus
// hand-written sequences for arbitration, forwarding and reset corner cases.
// Expectations follow FLASH_WR_FORWARD_EN when the macro is defined.
module tb_flash_sdram_bridge;

  localparam int DEPTH = 4;
  localparam int AW    = 25;

  logic          clk;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_din;
  logic          wr_ready;
  logic          wr_done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_dout;
  logic          rd_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic          mem_ack;
  logic [2:0]    wr_pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_din;
    logic          mem_ack;
    logic          exp_wr_done;
    logic          exp_wr_ready;
    logic          exp_mem_req;
    logic          exp_mem_we;
    logic [AW-1:0] exp_mem_addr;
    logic [7:0]    exp_mem_din;
    logic [2:0]    exp_pending;
  } vec_t;

  vec_t vectors[$];

  flash_sdram_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_din     (wr_din),
    .wr_ready   (wr_ready),
    .wr_done    (wr_done),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_dout    (rd_dout),
    .rd_done    (rd_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_ack    (mem_ack),
    .wr_pending (wr_pending)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic wr_req_i, input logic [AW-1:0] wr_addr_i,
                                 input logic [7:0] wr_din_i, input logic mem_ack_i,
                                 input logic done_e, input logic ready_e, input logic req_e,
                                 input logic we_e, input logic [AW-1:0] addr_e,
                                 input logic [7:0] din_e, input logic [2:0] pend_e);
    vec_t v;
    v.wr_req       = wr_req_i;
    v.wr_addr      = wr_addr_i;
    v.wr_din       = wr_din_i;
    v.mem_ack      = mem_ack_i;
    v.exp_wr_done  = done_e;
    v.exp_wr_ready = ready_e;
    v.exp_mem_req  = req_e;
    v.exp_mem_we   = we_e;
    v.exp_mem_addr = addr_e;
    v.exp_mem_din  = din_e;
    v.exp_pending  = pend_e;
    return v;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, got no handshake, expected one", name);
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_req   = v.wr_req;
    wr_addr  = v.wr_addr;
    wr_din   = v.wr_din;
    mem_ack  = v.mem_ack;
    mem_dout = 8'h00;
    rd_req   = 1'b0;
    stepCycle();
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("vec%0d wr_done", idx),    wr_done,    v.exp_wr_done);
    checkOutput($sformatf("vec%0d wr_ready", idx),   wr_ready,   v.exp_wr_ready);
    checkOutput($sformatf("vec%0d mem_req", idx),    mem_req,    v.exp_mem_req);
    checkOutput($sformatf("vec%0d mem_we", idx),     mem_we,     v.exp_mem_we);
    checkOutput($sformatf("vec%0d mem_addr", idx),   mem_addr,   v.exp_mem_addr);
    checkOutput($sformatf("vec%0d mem_din", idx),    mem_din,    v.exp_mem_din);
    checkOutput($sformatf("vec%0d wr_pending", idx), wr_pending, v.exp_pending);
    checkOutput($sformatf("vec%0d rd_done", idx),    rd_done,    1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " wr_ready"},   wr_ready,   1'b1);
    checkOutput({tag, " wr_done"},    wr_done,    1'b0);
    checkOutput({tag, " rd_done"},    rd_done,    1'b0);
    checkOutput({tag, " rd_dout"},    rd_dout,    8'h00);
    checkOutput({tag, " mem_req"},    mem_req,    1'b0);
    checkOutput({tag, " mem_we"},     mem_we,     1'b0);
    checkOutput({tag, " mem_addr"},   mem_addr,   25'h0);
    checkOutput({tag, " mem_din"},    mem_din,    8'h00);
    checkOutput({tag, " wr_pending"}, wr_pending, 3'd0);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_din   = '0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    mem_ack  = 1'b0;
    mem_dout = '0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  task automatic pushWrite(input logic [AW-1:0] addr, input logic [7:0] data);
    int waitCount = 0;
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_din  = data;
    do begin
      stepCycle();
      waitCount++;
    end while (!wr_done && waitCount < 20);
    wr_req = 1'b0;
    if (!wr_done) reportTimeout($sformatf("push 0x%0h", addr));
  endtask

  // Wait for a request, compare it, answer with a one-cycle ack and then
  // look at the read-complete pulse that should follow.
  task automatic serveTxn(input string name, input logic exp_we,
                          input logic [AW-1:0] exp_addr, input logic [7:0] exp_din,
                          input logic [7:0] rd_data, input logic exp_rd_done,
                          input logic [7:0] exp_rd_dout);
    int waitCount = 0;
    while (!mem_req && waitCount < 50) begin
      stepCycle();
      waitCount++;
    end
    if (!mem_req) begin
      reportTimeout(name);
      return;
    end
    checkOutput({name, " mem_we"},   mem_we,   exp_we);
    checkOutput({name, " mem_addr"}, mem_addr, exp_addr);
    if (exp_we) checkOutput({name, " mem_din"}, mem_din, exp_din);
    mem_ack  = 1'b1;
    mem_dout = rd_data;
    stepCycle();
    mem_ack  = 1'b0;
    mem_dout = 8'h00;
    checkOutput({name, " rd_done"}, rd_done, exp_rd_done);
    checkOutput({name, " mem_req drop"}, mem_req, 1'b0);
    if (exp_rd_done) begin
      checkOutput({name, " rd_dout"}, rd_dout, exp_rd_dout);
      rd_req = 1'b0;
    end
  endtask

  initial begin
    // Write path table: single write, stray ack, back-pressure, push+pop
    vectors.push_back(mkVec(1, 25'h010000, 8'h5A, 0, 1, 1, 0, 0, 25'h0,      8'h00, 3'd1));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 0, 0, 1, 1, 1, 25'h010000, 8'h5A, 3'd1));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 0, 0, 1, 1, 1, 25'h010000, 8'h5A, 3'd1));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 1, 0, 1, 0, 0, 25'h0,      8'h00, 3'd0));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 1, 0, 1, 0, 0, 25'h0,      8'h00, 3'd0));
    vectors.push_back(mkVec(1, 25'h100,    8'h01, 0, 1, 1, 0, 0, 25'h0,      8'h00, 3'd1));
    vectors.push_back(mkVec(1, 25'h101,    8'h02, 0, 0, 1, 1, 1, 25'h100,    8'h01, 3'd1));
    vectors.push_back(mkVec(1, 25'h101,    8'h02, 0, 1, 1, 1, 1, 25'h100,    8'h01, 3'd2));
    vectors.push_back(mkVec(1, 25'h102,    8'h03, 0, 0, 1, 1, 1, 25'h100,    8'h01, 3'd2));
    vectors.push_back(mkVec(1, 25'h102,    8'h03, 0, 1, 1, 1, 1, 25'h100,    8'h01, 3'd3));
    vectors.push_back(mkVec(1, 25'h103,    8'h04, 0, 0, 1, 1, 1, 25'h100,    8'h01, 3'd3));
    vectors.push_back(mkVec(1, 25'h103,    8'h04, 0, 1, 0, 1, 1, 25'h100,    8'h01, 3'd4));
    vectors.push_back(mkVec(1, 25'h104,    8'h05, 0, 0, 0, 1, 1, 25'h100,    8'h01, 3'd4));
    vectors.push_back(mkVec(1, 25'h104,    8'h05, 0, 0, 0, 1, 1, 25'h100,    8'h01, 3'd4));
    vectors.push_back(mkVec(1, 25'h104,    8'h05, 1, 0, 1, 0, 0, 25'h0,      8'h00, 3'd3));
    vectors.push_back(mkVec(1, 25'h104,    8'h05, 0, 1, 0, 1, 1, 25'h101,    8'h02, 3'd4));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 1, 0, 1, 0, 0, 25'h0,      8'h00, 3'd3));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 0, 0, 1, 1, 1, 25'h102,    8'h03, 3'd3));
    vectors.push_back(mkVec(1, 25'h105,    8'h06, 1, 1, 1, 0, 0, 25'h0,      8'h00, 3'd3));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 0, 0, 1, 1, 1, 25'h103,    8'h04, 3'd3));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 1, 0, 1, 0, 0, 25'h0,      8'h00, 3'd2));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 0, 0, 1, 1, 1, 25'h104,    8'h05, 3'd2));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 1, 0, 1, 0, 0, 25'h0,      8'h00, 3'd1));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 0, 0, 1, 1, 1, 25'h105,    8'h06, 3'd1));
    vectors.push_back(mkVec(0, 25'h0,      8'h00, 1, 0, 1, 0, 0, 25'h0,      8'h00, 3'd0));

    $display("[TB] reset state");
    doReset();
    checkResetState("reset");

    $display("[TB] write path vectors");
    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i]);
      checkVector(i, vectors[i]);
    end
    mem_ack = 1'b0;

    $display("[TB] read priority over queued writes");
    doReset();
    pushWrite(25'h300, 8'hA1);
    pushWrite(25'h301, 8'hA2);
    pushWrite(25'h302, 8'hA3);
    rd_req  = 1'b1;
    rd_addr = 25'h000100;
    stepCycle();
    stepCycle();
    checkOutput("prio busy rd_done", rd_done, 1'b0);
    checkOutput("prio busy mem_addr", mem_addr, 25'h300);
    serveTxn("prio w0", 1, 25'h300, 8'hA1, 8'h00, 0, 8'h00);
`ifdef FLASH_WR_FORWARD_EN
    serveTxn("prio rd", 0, 25'h100, 8'h00, 8'hC3, 1, 8'hC3);
    serveTxn("prio w1", 1, 25'h301, 8'hA2, 8'h00, 0, 8'h00);
    serveTxn("prio w2", 1, 25'h302, 8'hA3, 8'h00, 0, 8'h00);
`else
    serveTxn("prio w1", 1, 25'h301, 8'hA2, 8'h00, 0, 8'h00);
    serveTxn("prio w2", 1, 25'h302, 8'hA3, 8'h00, 0, 8'h00);
    serveTxn("prio rd", 0, 25'h100, 8'h00, 8'hC3, 1, 8'hC3);
`endif
    checkOutput("prio drained", wr_pending, 3'd0);

    $display("[TB] read-after-write to same address");
    doReset();
    pushWrite(25'h20, 8'h11);
    pushWrite(25'h20, 8'h22);
    rd_req  = 1'b1;
    rd_addr = 25'h20;
    stepCycle();
    checkOutput("raw busy rd_done", rd_done, 1'b0);
    serveTxn("raw w0", 1, 25'h20, 8'h11, 8'h00, 0, 8'h00);
`ifdef FLASH_WR_FORWARD_EN
    stepCycle();
    checkOutput("raw fwd rd_done", rd_done, 1'b1);
    checkOutput("raw fwd rd_dout", rd_dout, 8'h22);
    checkOutput("raw fwd mem_we", mem_we, 1'b1);
    checkOutput("raw fwd mem_din", mem_din, 8'h22);
    rd_req = 1'b0;
    serveTxn("raw w1", 1, 25'h20, 8'h22, 8'h00, 0, 8'h00);
`else
    serveTxn("raw w1", 1, 25'h20, 8'h22, 8'h00, 0, 8'h00);
    serveTxn("raw rd", 0, 25'h20, 8'h00, 8'h22, 1, 8'h22);
`endif
    checkOutput("raw drained", wr_pending, 3'd0);
    rd_req  = 1'b1;
    rd_addr = 25'h20;
    serveTxn("stale rd", 0, 25'h20, 8'h00, 8'h77, 1, 8'h77);

    $display("[TB] full queue issues a write before the read");
    doReset();
    pushWrite(25'h400, 8'h40);
    pushWrite(25'h401, 8'h41);
    pushWrite(25'h402, 8'h42);
    pushWrite(25'h403, 8'h43);
    checkOutput("full wr_ready", wr_ready, 1'b0);
    checkOutput("full wr_pending", wr_pending, 3'd4);
    rd_req  = 1'b1;
    rd_addr = 25'h500;
    serveTxn("full w0", 1, 25'h400, 8'h40, 8'h00, 0, 8'h00);
`ifdef FLASH_WR_FORWARD_EN
    serveTxn("full rd", 0, 25'h500, 8'h00, 8'h5E, 1, 8'h5E);
`endif
    serveTxn("full w1", 1, 25'h401, 8'h41, 8'h00, 0, 8'h00);
    serveTxn("full w2", 1, 25'h402, 8'h42, 8'h00, 0, 8'h00);
    serveTxn("full w3", 1, 25'h403, 8'h43, 8'h00, 0, 8'h00);
`ifndef FLASH_WR_FORWARD_EN
    serveTxn("full rd", 0, 25'h500, 8'h00, 8'h5E, 1, 8'h5E);
`endif

    $display("[TB] reset during an outstanding write");
    doReset();
    pushWrite(25'h600, 8'h60);
    pushWrite(25'h601, 8'h61);
    pushWrite(25'h602, 8'h62);
    checkOutput("midreset pre mem_req", mem_req, 1'b1);
    checkOutput("midreset pre pending", wr_pending, 3'd3);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkResetState("midreset");
    mem_ack  = 1'b1;
    mem_dout = 8'hEE;
    stepCycle();
    mem_ack  = 1'b0;
    mem_dout = 8'h00;
    checkOutput("late ack pending", wr_pending, 3'd0);
    checkOutput("late ack rd_done", rd_done, 1'b0);
    checkOutput("late ack mem_req", mem_req, 1'b0);
    stepCycle();
    checkOutput("late ack idle mem_req", mem_req, 1'b0);
    checkOutput("late ack idle wr_ready", wr_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
